topk_acc_8: RTL and testbench

Streaming top-8 accumulator directly downstream of the 8-input bitonic sorter. It consumes one descending-sorted 8-element block per accepted beat and merges it with a stored running top-8. When the last block of a frame arrives, it presents the frame's top-8 in descending order on a valid/ready output. The merge uses a half-cleaner max stage followed by an 8-input bitonic merge network, so no full re-sort is needed.

---
 rtl/topk_pkg.sv | 46 ++++
 rtl/topk_bitonic_merge_8.sv | 61 ++++++
 rtl/topk_acc_8.sv | 202 ++++++++++++++++++++
 tb/tb_topk_acc_8.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/topk_pkg.sv
// Shared definitions for the top-K accumulator family: state encoding, K,
// and the signed/unsigned greater-than helpers used by every compare stage.
package topk_pkg;

  localparam int TOPK_K  = 8;
  // Common compare width; element values are widened to this before comparing.
  localparam int TOPK_XW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } acc_state_t;

  // Widen a w-bit value (held in the low bits of x) to TOPK_XW bits,
  // sign-extending when sgn is set and zero-extending otherwise.
  function automatic logic [TOPK_XW-1:0] topk_ext(input logic [TOPK_XW-1:0] x,
                                                  input int w,
                                                  input logic sgn);
    logic [TOPK_XW-1:0] shl_s;
    logic [TOPK_XW-1:0] res_s;
    int                 sh_s;
    sh_s  = TOPK_XW - w;
    shl_s = x << sh_s;
    if (sgn) begin
      res_s = $unsigned($signed(shl_s) >>> sh_s);
    end else begin
      res_s = x;
    end
    return res_s;
  endfunction

  // a > b on widened operands, signed or unsigned.
  function automatic logic cmp_gt(input logic [TOPK_XW-1:0] a,
                                  input logic [TOPK_XW-1:0] b,
                                  input logic sgn);
    logic gt_s;
    if (sgn) begin
      gt_s = ($signed(a) > $signed(b));
    end else begin
      gt_s = (a > b);
    end
    return gt_s;
  endfunction

endpackage

// File: rtl/topk_bitonic_merge_8.sv
// 8-input bitonic merge network: takes a bitonic sequence and returns it
// sorted descending (y_o[0] largest). Three levels of four compare-exchanges.
// Purely combinational, so it can be reused inside wider accumulators.
module topk_bitonic_merge_8
  import topk_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                              sign_i,
  input  logic [TOPK_K-1:0][DATAWIDTH-1:0]  x_i,
  output logic [TOPK_K-1:0][DATAWIDTH-1:0]  y_o
);

  function automatic logic gt_w(input logic [DATAWIDTH-1:0] a,
                                input logic [DATAWIDTH-1:0] b,
                                input logic sgn);
    return cmp_gt(topk_ext(TOPK_XW'(a), DATAWIDTH, sgn),
                  topk_ext(TOPK_XW'(b), DATAWIDTH, sgn), sgn);
  endfunction

  logic [DATAWIDTH-1:0] lvl0_s [TOPK_K];
  logic [DATAWIDTH-1:0] lvl1_s [TOPK_K];
  logic [DATAWIDTH-1:0] lvl2_s [TOPK_K];
  logic [DATAWIDTH-1:0] lvl3_s [TOPK_K];

  for (genvar g = 0; g < TOPK_K; g++) begin : g_io
    assign lvl0_s[g] = x_i[g];
    assign y_o[g]    = lvl3_s[g];
  end

  // Level 1: distance-4 half-cleaner, larger element to the lower index.
  for (genvar g = 0; g < 4; g++) begin : g_l1
    localparam int A = g;
    localparam int B = g + 4;
    logic swap_s;
    assign swap_s    = gt_w(lvl0_s[B], lvl0_s[A], sign_i);
    assign lvl1_s[A] = swap_s ? lvl0_s[B] : lvl0_s[A];
    assign lvl1_s[B] = swap_s ? lvl0_s[A] : lvl0_s[B];
  end

  // Level 2: distance-2 compare-exchange inside each half.
  for (genvar g = 0; g < 4; g++) begin : g_l2
    localparam int A = (g / 2) * 4 + (g % 2);
    localparam int B = A + 2;
    logic swap_s;
    assign swap_s    = gt_w(lvl1_s[B], lvl1_s[A], sign_i);
    assign lvl2_s[A] = swap_s ? lvl1_s[B] : lvl1_s[A];
    assign lvl2_s[B] = swap_s ? lvl1_s[A] : lvl1_s[B];
  end

  // Level 3: adjacent compare-exchange finishes the descending order.
  for (genvar g = 0; g < 4; g++) begin : g_l3
    localparam int A = 2 * g;
    localparam int B = A + 1;
    logic swap_s;
    assign swap_s    = gt_w(lvl2_s[B], lvl2_s[A], sign_i);
    assign lvl3_s[A] = swap_s ? lvl2_s[B] : lvl2_s[A];
    assign lvl3_s[B] = swap_s ? lvl2_s[A] : lvl2_s[B];
  end

endmodule

// File: rtl/topk_acc_8.sv
// Streaming top-8 accumulator. Merges descending-sorted 8-element blocks
// into a running top-8 and presents the frame result on valid/ready.
// Optional feature macro: TOPK_ACC_PIPE_EN registers the max-stage output
// before the merge network (one block every 2 cycles, result latency 2).
module topk_acc_8
  import topk_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic                              last_i,
  input  logic                              sign_i,
  input  logic [TOPK_K-1:0][DATAWIDTH-1:0]  x_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [TOPK_K-1:0][DATAWIDTH-1:0]  y_o,
  output logic [CNTWIDTH-1:0]               blk_cnt_o
);

  localparam int VW = TOPK_K * DATAWIDTH;

  function automatic logic gt_w(input logic [DATAWIDTH-1:0] a,
                                input logic [DATAWIDTH-1:0] b,
                                input logic sgn);
    return cmp_gt(topk_ext(TOPK_XW'(a), DATAWIDTH, sgn),
                  topk_ext(TOPK_XW'(b), DATAWIDTH, sgn), sgn);
  endfunction

  acc_state_t                      state_r, state_nxt_s;
  logic [TOPK_K-1:0][DATAWIDTH-1:0] acc_r, acc_nxt_s;
  logic [TOPK_K-1:0][DATAWIDTH-1:0] max_s, merge_in_s, merged_s;
  logic [TOPK_K-1:0][DATAWIDTH-1:0] y_r, y_nxt_s;
  logic [CNTWIDTH-1:0]             cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [CNTWIDTH-1:0]             blk_cnt_r, blk_cnt_nxt_s;
  logic                            sign_r, sign_nxt_s;
  logic                            valid_r, valid_nxt_s;
  logic                            ready_r, ready_nxt_s;
  logic                            accept_s;
  logic                            busy_nxt_s;

`ifdef TOPK_ACC_PIPE_EN
  logic                            busy_r;
  logic                            last_r, last_nxt_s;
  logic [TOPK_K-1:0][DATAWIDTH-1:0] stage_r, stage_nxt_s;
`endif

  assign accept_s  = valid_i && ready_r;
  assign cnt_inc_s = (cnt_r == {CNTWIDTH{1'b1}}) ? cnt_r : cnt_r + CNTWIDTH'(1);

  // Max stage: stored descending vs incoming reversed (ascending) gives a
  // bitonic sequence that holds the top-8 of the union.
  for (genvar g = 0; g < TOPK_K; g++) begin : g_max
    assign max_s[g] = gt_w(x_i[TOPK_K-1-g], acc_r[g], sign_r) ? x_i[TOPK_K-1-g] : acc_r[g];
  end

`ifdef TOPK_ACC_PIPE_EN
  assign merge_in_s = stage_r;
`else
  assign merge_in_s = max_s;
`endif

  topk_bitonic_merge_8 #(
    .DATAWIDTH (DATAWIDTH)
  ) u_merge (
    .sign_i (sign_r),
    .x_i    (merge_in_s),
    .y_o    (merged_s)
  );

  // Next-state, accumulator, counter and registered-output computation.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sign_nxt_s  = sign_r;
    busy_nxt_s  = 1'b0;
`ifdef TOPK_ACC_PIPE_EN
    busy_nxt_s  = busy_r;
    last_nxt_s  = last_r;
    stage_nxt_s = stage_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sign_nxt_s = sign_i;
          cnt_nxt_s  = CNTWIDTH'(1);
`ifdef TOPK_ACC_PIPE_EN
          // First block skips the max stage but still goes through the
          // pipeline register so every block sees the same latency.
          stage_nxt_s = x_i;
          busy_nxt_s  = 1'b1;
          last_nxt_s  = last_i;
          state_nxt_s = ACC;
`else
          acc_nxt_s   = x_i;
          state_nxt_s = last_i ? OUT : ACC;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
`ifdef TOPK_ACC_PIPE_EN
        if (busy_r) begin
          acc_nxt_s   = merged_s;
          busy_nxt_s  = 1'b0;
          state_nxt_s = last_r ? OUT : ACC;
        end else if (accept_s) begin
          stage_nxt_s = max_s;
          busy_nxt_s  = 1'b1;
          last_nxt_s  = last_i;
          cnt_nxt_s   = cnt_inc_s;
        end else begin
          state_nxt_s = ACC;
        end
`else
        if (accept_s) begin
          acc_nxt_s   = merged_s;
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = last_i ? OUT : ACC;
        end else begin
          state_nxt_s = ACC;
        end
`endif
      end
      OUT: begin
        if (ready_i) begin
          state_nxt_s = IDLE;
          acc_nxt_s   = {VW{1'b0}};
          cnt_nxt_s   = {CNTWIDTH{1'b0}};
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = {VW{1'b0}};
        cnt_nxt_s   = {CNTWIDTH{1'b0}};
      end
    endcase

    // Result fields are only non-zero while the result is presented.
    if (state_nxt_s == OUT) begin
      valid_nxt_s   = 1'b1;
      y_nxt_s       = acc_nxt_s;
      blk_cnt_nxt_s = cnt_nxt_s;
    end else begin
      valid_nxt_s   = 1'b0;
      y_nxt_s       = {VW{1'b0}};
      blk_cnt_nxt_s = {CNTWIDTH{1'b0}};
    end
    ready_nxt_s = (state_nxt_s != OUT) && !busy_nxt_s;
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= IDLE;
      acc_r     <= {VW{1'b0}};
      cnt_r     <= {CNTWIDTH{1'b0}};
      sign_r    <= 1'b0;
      valid_r   <= 1'b0;
      ready_r   <= 1'b1;
      y_r       <= {VW{1'b0}};
      blk_cnt_r <= {CNTWIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sign_r    <= sign_nxt_s;
      valid_r   <= valid_nxt_s;
      ready_r   <= ready_nxt_s;
      y_r       <= y_nxt_s;
      blk_cnt_r <= blk_cnt_nxt_s;
    end
  end

`ifdef TOPK_ACC_PIPE_EN
  // Pipeline register between the max stage and the merge network.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_r  <= 1'b0;
      last_r  <= 1'b0;
      stage_r <= {VW{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      last_r  <= last_nxt_s;
      stage_r <= stage_nxt_s;
    end
  end
`endif

  assign ready_o   = ready_r;
  assign valid_o   = valid_r;
  assign y_o       = y_r;
  assign blk_cnt_o = blk_cnt_r;

endmodule

// File: tb/tb_topk_acc_8.sv
// Self-checking bench for topk_acc_8 (DATAWIDTH=8, CNTWIDTH=4 so counter
// saturation is reachable). Honours TOPK_ACC_PIPE_EN for timing checks.
module tb_topk_acc_8;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic             valid_i, last_i, sign_i, ready_i;
  logic [7:0][7:0]  x_i;
  logic             valid_o, ready_o;
  logic [7:0][7:0]  y_o;
  logic [3:0]       blk_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  frame_q[$];
  int          frame_n = 0;
  bit          frame_sgn = 1'b0;

`ifdef TOPK_ACC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  topk_acc_8 #(.DATAWIDTH(8), .CNTWIDTH(4)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .last_i    (last_i),
    .sign_i    (sign_i),
    .x_i       (x_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .y_o       (y_o),
    .blk_cnt_o (blk_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [7:0] v, input bit s);
    if (s) return int'($signed(v));
    return int'(v);
  endfunction

  task automatic sort_block(inout logic [7:0] b[8], input bit s);
    logic [7:0] t;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (key(b[j], s) < key(b[j+1], s)) begin
          t = b[j]; b[j] = b[j+1]; b[j+1] = t;
        end
  endtask

  task automatic rand_block(input bit s, output logic [7:0] b[8]);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
    sort_block(b, s);
  endtask

  // Reference model: collect every element of the frame, full sort, keep 8.
  task automatic model_block(input logic [7:0] b[8], input bit last, input bit fsgn);
    exp_t e;
    logic [7:0] t;
    if (frame_n == 0) frame_sgn = fsgn;
    for (int i = 0; i < 8; i++) frame_q.push_back(b[i]);
    frame_n++;
    if (last) begin
      for (int i = 0; i < frame_q.size(); i++)
        for (int j = 0; j < frame_q.size() - 1 - i; j++)
          if (key(frame_q[j], frame_sgn) < key(frame_q[j+1], frame_sgn)) begin
            t = frame_q[j]; frame_q[j] = frame_q[j+1]; frame_q[j+1] = t;
          end
      e.y = 64'h0;
      for (int i = 0; i < 8; i++) e.y[i*8 +: 8] = frame_q[i];
      e.cnt = (frame_n > 15) ? 4'd15 : 4'(frame_n);
      exp_q.push_back(e);
      frame_q.delete();
      frame_n = 0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_valid_o"},   64'(valid_o),   64'd0);
    check_val({tag, "_ready_o"},   64'(ready_o),   64'd1);
    check_val({tag, "_y_o"},       y_o,            64'd0);
    check_val({tag, "_blk_cnt_o"}, 64'(blk_cnt_o), 64'd0);
  endtask

  // Drive one block, wait (bounded) for acceptance, then check handshake timing.
  task automatic send_block(input logic [7:0] b[8], input bit last, input bit sgn_drv, input bit fsgn);
    int waits;
    @(posedge clk); #1;
    valid_i = 1'b1; last_i = last; sign_i = sgn_drv;
    for (int i = 0; i < 8; i++) x_i[i] = b[i];
    waits = 0;
    @(negedge clk);
    while (!ready_o && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!ready_o) check_val("accept_timeout", 64'(ready_o), 64'd1);
    model_block(b, last, fsgn);
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0;
    @(negedge clk);
    check_val("ready_after_accept", 64'(ready_o), 64'(!PIPE && !last));
    if (last) begin
      if (PIPE) begin
        check_val("latency_early", 64'(valid_o), 64'd0);
        @(negedge clk);
      end
      check_val("latency_valid", 64'(valid_o), 64'd1);
    end
  endtask

  // Output monitor: pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rstn_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("y_o", y_o, e.y);
        check_val("blk_cnt_o", 64'(blk_cnt_o), 64'(e.cnt));
      end
    end else if (rstn_i && !valid_o) begin
      check_val("idle_y_zero", y_o, 64'd0);
      check_val("idle_cnt_zero", 64'(blk_cnt_o), 64'd0);
    end
  end

  initial begin
    logic [7:0] b[8];
    logic [7:0] c[8];
    logic [7:0] s1[8];
    logic [7:0] s2[8];
    logic [63:0] y_bp;
    int nb;
    bit fs;

    rstn_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; sign_i = 1'b0; ready_i = 1'b1;
    x_i = 64'h0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk); rstn_i = 1'b1;

    // Single-block frame
    b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    send_block(b, 1'b1, 1'b0, 1'b0);

    // Two-block merge
    b = '{8'd20, 8'd15, 8'd10, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_block(b, 1'b0, 1'b0, 1'b0);
    b = '{8'd18, 8'd12, 8'd11, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    send_block(b, 1'b1, 1'b0, 1'b0);

    // Signed frame, then the same values compared unsigned
    s1 = '{8'h03, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
    s2 = '{8'h02, 8'hFF, 8'hFA, 8'hF9, 8'hF8, 8'hF8, 8'hF8, 8'hF8};
    send_block(s1, 1'b0, 1'b1, 1'b1);
    send_block(s2, 1'b1, 1'b1, 1'b1);
    sort_block(s1, 1'b0);
    sort_block(s2, 1'b0);
    send_block(s1, 1'b0, 1'b0, 1'b0);
    send_block(s2, 1'b1, 1'b0, 1'b0);

    // Output backpressure with the next block already waiting
    @(posedge clk); #1; ready_i = 1'b0;
    b = '{8'd77, 8'd66, 8'd55, 8'd44, 8'd33, 8'd22, 8'd11, 8'd0};
    y_bp = {8'd0, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77};
    send_block(b, 1'b1, 1'b0, 1'b0);
    c = '{8'd5, 8'd5, 8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2};
    @(posedge clk); #1;
    valid_i = 1'b1; last_i = 1'b1; sign_i = 1'b0;
    for (int i = 0; i < 8; i++) x_i[i] = c[i];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_ready_low", 64'(ready_o), 64'd0);
      check_val("bp_valid_high", 64'(valid_o), 64'd1);
      check_val("bp_y_stable", y_o, y_bp);
    end
    @(posedge clk); #1; ready_i = 1'b1;
    @(negedge clk);
    check_val("no_overlap_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    check_val("ready_after_out", 64'(ready_o), 64'd1);
    check_val("valid_after_out", 64'(valid_o), 64'd0);
    model_block(c, 1'b1, 1'b0);
    @(posedge clk); #1; valid_i = 1'b0; last_i = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a frame
    for (int k = 0; k < 3; k++) begin
      rand_block(1'b0, b);
      send_block(b, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #3; rstn_i = 1'b0;
    frame_q.delete(); frame_n = 0;
    @(negedge clk);
    check_reset_vals("midreset");
    @(negedge clk); rstn_i = 1'b1;
    b = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    send_block(b, 1'b1, 1'b0, 1'b0);

    // Random frames; sign_i is flipped on non-first beats and must be ignored
    for (int f = 0; f < 6; f++) begin
      nb = $urandom_range(1, 5);
      fs = 1'($urandom_range(0, 1));
      for (int k = 0; k < nb; k++) begin
        rand_block(fs, b);
        send_block(b, (k == nb - 1), (k == 0) ? fs : !fs, fs);
      end
    end

    // Block counter saturation (CNTWIDTH=4 -> 15)
    for (int k = 0; k < 18; k++) begin
      rand_block(1'b0, b);
      send_block(b, (k == 17), 1'b0, 1'b0);
    end

    // Drain the scoreboard
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    check_val("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
